pipe_run_monitor: RTL

//  Synthesizable run controller/checker for the pipelined core, replacing fixed-delay bench sequencing.

---
 rtl/pipe_run_monitor_if.sv | 31 +++
 rtl/pipe_run_monitor.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipe_run_monitor_if.sv
// pipe_run_monitor_if: core observation, status and store-log signals of the run monitor
interface pipe_run_monitor_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_rst;
  logic              running;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [31:0]       cycle_count;
  logic [15:0]       store_count;
  logic              log_valid;
  logic              log_ready;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_data;
  logic              log_overflow;
  modport master (
    output start, pc, inst, mem_write, mem_addr, mem_wdata, log_ready,
    input  core_rst, running, done, pass, timeout, cycle_count, store_count,
           log_valid, log_addr, log_data, log_overflow
  );
  modport slave (
    input  start, pc, inst, mem_write, mem_addr, mem_wdata, log_ready,
    output core_rst, running, done, pass, timeout, cycle_count, store_count,
           log_valid, log_addr, log_data, log_overflow
  );
endinterface

// File: rtl/pipe_run_monitor.sv
// pipe_run_monitor: drives core reset, times the run, detects halt/timeout, checks signature, logs stores
module pipe_run_monitor #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                RESET_CYCLES = 2,
  parameter int                MAX_CYCLES   = 400,
  parameter logic [DATA_W-1:0] HALT_INST    = 32'hFC000000,
  parameter int                HALT_STABLE  = 4,
  parameter logic [ADDR_W-1:0] SIG_ADDR     = 32'd2000,
  parameter logic [DATA_W-1:0] SIG_EXPECT   = 32'd0,
  parameter int                LOG_DEPTH    = 8
) (
  input logic             clk,
  input logic             rst,
  pipe_run_monitor_if.slave bus
);
  localparam int PW = $clog2(LOG_DEPTH);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_STABLE + 1);
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
  state_t                   state_q;
  logic [RW-1:0]            rcnt_q;
  logic [SW-1:0]            stab_q, stab_d;
  logic [ADDR_W-1:0]        pc_prev_q;
  logic [31:0]              cyc_q;
  logic [15:0]              st_q;
  logic                     sig_seen_q, sig_ok_q, timeout_q, overflow_q;
  logic                     core_rst_q, running_q, done_q;
  logic [ADDR_W+DATA_W-1:0] mem_q [LOG_DEPTH];
  logic [PW-1:0]            wp_q, rp_q;
  logic [PW:0]              occ_q;
  logic                     same, halt, tmo, cap, pop, push, drop, enter;
  always_comb begin
    same   = bus.pc == pc_prev_q;
    stab_d = same ? stab_q + SW'(1) : '0;
    halt   = running_q & ((bus.inst == HALT_INST) | (same & (stab_q == SW'(HALT_STABLE - 1))));
    tmo    = running_q & ~halt & (cyc_q == 32'(MAX_CYCLES - 1));
    cap    = running_q & bus.mem_write;
    pop    = (occ_q != '0) & bus.log_ready;
    // a full FIFO still accepts a store when its head leaves in the same cycle
    push   = cap & ((occ_q != (PW+1)'(LOG_DEPTH)) | pop);
    drop   = cap & ~push;
    enter  = bus.start & ((state_q == IDLE) | (state_q == DONE));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      stab_q     <= '0;
      pc_prev_q  <= '0;
      cyc_q      <= '0;
      st_q       <= '0;
      sig_seen_q <= 1'b0;
      sig_ok_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      occ_q      <= '0;
    end else begin
      pc_prev_q <= bus.pc;
      if (enter) begin
        state_q    <= RESET;
        rcnt_q     <= '0;
        stab_q     <= '0;
        cyc_q      <= '0;
        st_q       <= '0;
        sig_seen_q <= 1'b0;
        sig_ok_q   <= 1'b0;
        timeout_q  <= 1'b0;
        overflow_q <= 1'b0;
        core_rst_q <= 1'b1;
        done_q     <= 1'b0;
        wp_q       <= '0;
        rp_q       <= '0;
        occ_q      <= '0;
      end else begin
        if (push) begin
          mem_q[wp_q] <= {bus.mem_addr, bus.mem_wdata};
          wp_q        <= wp_q + PW'(1);
        end
        if (pop) rp_q <= rp_q + PW'(1);
        occ_q <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
        if (drop) overflow_q <= 1'b1;
        if (state_q == RESET) begin
          if (rcnt_q == RW'(RESET_CYCLES - 1)) begin
            state_q    <= RUN;
            running_q  <= 1'b1;
            core_rst_q <= 1'b0;
          end else rcnt_q <= rcnt_q + RW'(1);
        end
        if (state_q == RUN) begin
          stab_q <= stab_d;
          if (cap) begin
            st_q <= st_q + 16'(st_q != 16'hFFFF);
            if (bus.mem_addr == SIG_ADDR) begin
              sig_seen_q <= 1'b1;
              sig_ok_q   <= bus.mem_wdata == SIG_EXPECT;
            end
          end
          if (halt | tmo) begin
            state_q    <= DONE;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
            core_rst_q <= 1'b1;
            timeout_q  <= tmo;
          end else cyc_q <= cyc_q + 32'd1;
        end
      end
    end
  end
  assign bus.core_rst                  = core_rst_q;
  assign bus.running                   = running_q;
  assign bus.done                      = done_q;
  assign bus.pass                      = done_q & sig_seen_q & sig_ok_q & ~timeout_q;
  assign bus.timeout                   = timeout_q;
  assign bus.cycle_count               = cyc_q;
  assign bus.store_count               = st_q;
  assign bus.log_valid                 = occ_q != '0;
  assign {bus.log_addr, bus.log_data}  = mem_q[rp_q];
  assign bus.log_overflow              = overflow_q;
endmodule
